// File: rtl/key_event_scheduler.sv
// Re-times PS/2 key events so each one is held for HOLD_CYCLES clocks; first strobe one clock after capture.
// Input cannot be stalled: events that arrive when the queue is full and nothing pops are dropped and flagged.

module kes_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         push_acc;

  // Extra pointer bit separates full from empty; a pop frees the slot in the same cycle.
  assign count    = wptr - rptr;
  assign push_rdy = (count != (AW+1)'(DEPTH)) || pop;
  assign push_acc = push_vld && push_rdy;
  assign head_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

module key_event_scheduler #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [10:0] ps2_key_out,
  output logic        busy,
  output logic [6:0]  pending,
  output logic        overflow
);
  localparam int              CW          = $clog2(DEPTH) + 1;
  localparam logic [15:0]     HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic          last_tgl;
  logic          push_vld;
  logic          push_rdy;
  logic          push_acc;
  logic          pop;
  logic [9:0]    head;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] fifo_cnt_nxt;

  // An event is a toggle of bit 10; level changes on [9:0] alone are not events.
  assign push_vld     = ps2_key[10] != last_tgl;
  assign push_acc     = push_vld && push_rdy;
  assign fifo_cnt_nxt = fifo_cnt + CW'(push_acc) - CW'(pop);
  assign pending      = 7'(fifo_cnt);

  kes_fifo #(
    .W     (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (ps2_key[9:0]),
    .push_rdy (push_rdy),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          pop       = 1'b1;
          cnt_nxt   = HOLD_RELOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (fifo_cnt != '0) begin
          pop     = 1'b1;
          cnt_nxt = HOLD_RELOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      ps2_key_out <= 11'd0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      last_tgl    <= ps2_key[10];
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_tgl <= ps2_key[10];
      if (pop) ps2_key_out <= {~ps2_key_out[10], head};
      // Built from next-state values so it lines up with state and pending.
      busy <= (state_nxt == HOLD) || (fifo_cnt_nxt != '0);
      if (push_vld && !push_rdy) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench: instance a (HOLD 4) for ordering/reset, instance b (HOLD 100) for hold time and overflow.
module tb_key_event_scheduler;
  logic        clk = 1'b0;
  logic        ra, rb;
  logic [10:0] ka, kb;
  logic [10:0] oa, ob;
  logic        busy_a, busy_b, ovf_a, ovf_b;
  logic [6:0]  pend_a, pend_b;

  int total = 0;
  int bad   = 0;

  logic       tgl_b;
  logic       exp_t;
  logic [9:0] exp_q [0:15];

  always #5 clk = ~clk;

  key_event_scheduler #(.DEPTH(8), .HOLD_CYCLES(4)) dut_a (
    .clk(clk), .reset(ra), .ps2_key(ka), .ps2_key_out(oa),
    .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
  );

  key_event_scheduler #(.DEPTH(8), .HOLD_CYCLES(100)) dut_b (
    .clk(clk), .reset(rb), .ps2_key(kb), .ps2_key_out(ob),
    .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] code, input logic pressed);
    tgl_b = ~tgl_b;
    kb    = {tgl_b, pressed, 1'b0, code};
    tick();
  endtask

  initial begin
    ra = 1'b1; rb = 1'b1; ka = 11'h400; kb = 11'h000; tgl_b = 1'b0;
    repeat (2) tick();
    chk("rst_out_a", 32'(oa), 32'h0);
    chk("rst_ovf_a", 32'(ovf_a), 32'h0);
    ra = 1'b0; rb = 1'b0;
    repeat (3) tick();
    chk("post_rst_out_a", 32'(oa), 32'h0);
    chk("post_rst_pend_a", 32'(pend_a), 32'h0);
    chk("post_rst_busy_a", 32'(busy_a), 32'h0);
    ka = 11'h4FF;
    repeat (2) tick();
    chk("level_only_pend", 32'(pend_a), 32'h0);
    chk("level_only_out", 32'(oa), 32'h0);

    // Three events on consecutive clocks, strobes 4 clocks apart.
    ka = 11'h21C; tick();
    chk("a_push1_pend", 32'(pend_a), 32'd1);
    ka = 11'h41C; tick();
    chk("a_ev1_out", 32'(oa), 32'h61C);
    chk("a_ev1_busy", 32'(busy_a), 32'h1);
    chk("a_ev1_pend", 32'(pend_a), 32'd1);
    ka = 11'h215; tick();
    chk("a_push3_pend", 32'(pend_a), 32'd2);
    repeat (2) tick();
    chk("a_ev1_stable", 32'(oa), 32'h61C);
    tick();
    chk("a_ev2_out", 32'(oa), 32'h01C);
    repeat (3) tick();
    chk("a_ev2_stable", 32'(oa), 32'h01C);
    tick();
    chk("a_ev3_out", 32'(oa), 32'h615);
    chk("a_ev3_pend", 32'(pend_a), 32'd0);
    repeat (3) tick();
    chk("a_hold_busy", 32'(busy_a), 32'h1);
    tick();
    chk("a_idle_busy", 32'(busy_a), 32'h0);
    chk("a_idle_out", 32'(oa), 32'h615);

    // Reset in the middle of a hold with three queued.
    ka = 11'h611; tick();
    ka = 11'h011; tick();
    ka = 11'h712; tick();
    ka = 11'h012; tick();
    ka = 11'h622; tick();
    tick();
    tick();
    chk("a_pre_rst_out", 32'(oa), 32'h411);
    chk("a_pre_rst_pend", 32'(pend_a), 32'd3);
    ra = 1'b1; tick();
    chk("a_mid_rst_out", 32'(oa), 32'h0);
    chk("a_mid_rst_pend", 32'(pend_a), 32'd0);
    chk("a_mid_rst_busy", 32'(busy_a), 32'h0);
    ra = 1'b0;
    repeat (20) tick();
    chk("a_after_rst_out", 32'(oa), 32'h0);
    chk("a_after_rst_pend", 32'(pend_a), 32'd0);

    // Single press, held for 100 clocks.
    send_b(8'h1C, 1'b1);
    chk("b_press_pend", 32'(pend_b), 32'd1);
    chk("b_press_out0", 32'(ob), 32'h0);
    tick();
    chk("b_press_out", 32'(ob), 32'h61C);
    chk("b_press_busy", 32'(busy_b), 32'h1);
    repeat (98) tick();
    chk("b_hold_out", 32'(ob), 32'h61C);
    tick();
    chk("b_hold_end_busy", 32'(busy_b), 32'h1);
    tick();
    chk("b_idle_busy", 32'(busy_b), 32'h0);
    chk("b_idle_out", 32'(ob), 32'h61C);

    // Ten events in ten clocks: one issued, eight queued, last dropped.
    exp_t = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q[i] = {(i % 2 == 0), 1'b0, 8'(8'h30 + i)};
      send_b(8'(8'h30 + i), (i % 2 == 0));
    end
    exp_t = ~exp_t;
    chk("b_ovf_pend", 32'(pend_b), 32'd8);
    chk("b_ovf_flag", 32'(ovf_b), 32'h1);
    chk("b_ovf_head", 32'(ob[9:0]), 32'(exp_q[0]));
    repeat (91) tick();
    chk("b_ovf_e0_stable", 32'(ob[9:0]), 32'(exp_q[0]));
    tick();
    exp_t = ~exp_t;
    chk("b_ovf_e1", 32'(ob[9:0]), 32'(exp_q[1]));
    chk("b_ovf_e1_tgl", 32'(ob[10]), 32'(exp_t));
    chk("b_ovf_e1_pend", 32'(pend_b), 32'd7);
    for (int k = 2; k <= 8; k++) begin
      repeat (99) tick();
      chk("b_ovf_hold", 32'(ob[9:0]), 32'(exp_q[k-1]));
      tick();
      exp_t = ~exp_t;
      chk("b_ovf_order", 32'(ob[9:0]), 32'(exp_q[k]));
      chk("b_ovf_tgl", 32'(ob[10]), 32'(exp_t));
      chk("b_ovf_drain_pend", 32'(pend_b), 32'(8 - k));
    end
    repeat (100) tick();
    chk("b_ovf_last_lost", 32'(ob[9:0]), 32'(exp_q[8]));
    chk("b_ovf_done_busy", 32'(busy_b), 32'h0);
    chk("b_ovf_sticky", 32'(ovf_b), 32'h1);

    // Full queue plus push on the same edge as the hold-expiry pop.
    rb = 1'b1; tick();
    rb = 1'b0; tick();
    chk("b_rst_ovf", 32'(ovf_b), 32'h0);
    exp_t = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_q[i] = {(i % 2 == 1), 1'b0, 8'(8'h50 + i)};
      send_b(8'(8'h50 + i), (i % 2 == 1));
    end
    exp_t = ~exp_t;
    chk("b_full_pend", 32'(pend_b), 32'd8);
    chk("b_full_ovf", 32'(ovf_b), 32'h0);
    repeat (92) tick();
    exp_q[9] = {1'b1, 1'b0, 8'h77};
    send_b(8'h77, 1'b1);
    exp_t = ~exp_t;
    chk("b_swap_pend", 32'(pend_b), 32'd8);
    chk("b_swap_ovf", 32'(ovf_b), 32'h0);
    chk("b_swap_out", 32'(ob[9:0]), 32'(exp_q[1]));
    for (int k = 2; k <= 9; k++) begin
      repeat (99) tick();
      tick();
      exp_t = ~exp_t;
      chk("b_swap_order", 32'(ob[9:0]), 32'(exp_q[k]));
      chk("b_swap_tgl", 32'(ob[10]), 32'(exp_t));
    end
    repeat (100) tick();
    chk("b_swap_done_busy", 32'(busy_b), 32'h0);
    chk("b_swap_done_ovf", 32'(ovf_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
